// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_pkg
// Purpose  : Shared constants and types for the VGA framebuffer fill master.
//            Holds the default framebuffer geometry and addresses, the fill
//            FSM state type and the width used for pixel counters.
// Revision : 1.0 - initial release
// ============================================================================
package vga_fb_pkg;

    localparam logic [31:0] FB_BASE_DEF      = 32'h2100_0000;
    localparam logic [31:0] FB_SYNC_ADDR_DEF = 32'h211F_FFFC;
    localparam int          FB_W_DEF         = 640;
    localparam int          FB_H_DEF         = 480;

    // 11 bits so that a 10-bit coordinate plus a 10-bit extent never wraps.
    localparam int          PIX_CNT_W        = 11;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SETUP       = 3'd1,
        ST_ACCESS      = 3'd2,
        ST_SYNC_SETUP  = 3'd3,
        ST_SYNC_ACCESS = 3'd4,
        ST_FINISH      = 3'd5
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_fb_fill_apb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_fill_apb_master_if
// Purpose  : APB bus bundle between the fill master and the framebuffer
//            completer.
// Ports    : master modport drives paddr/psel/penable/pwrite/pprot/pwdata/
//            pstrb and samples pready/pslverr/prdata; slave is the mirror.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_fb_fill_apb_master_if;

    logic [31:0] m_paddr;
    logic        m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [2:0]  m_pprot;
    logic [31:0] m_pwdata;
    logic [3:0]  m_pstrb;
    logic        m_pready;
    logic        m_pslverr;
    logic [31:0] m_prdata;

    modport master (
        output m_paddr, m_psel, m_penable, m_pwrite, m_pprot, m_pwdata, m_pstrb,
        input  m_pready, m_pslverr, m_prdata
    );

    modport slave (
        input  m_paddr, m_psel, m_penable, m_pwrite, m_pprot, m_pwdata, m_pstrb,
        output m_pready, m_pslverr, m_prdata
    );

endinterface
`default_nettype wire

// File: rtl/vga_fill_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_fill_addr_gen
// Purpose  : Column/row walker for a rectangle fill. Clips the rectangle to
//            the framebuffer on load, then produces the pixel byte address
//            in row-major order.
// Ports    : clock, reset      - clock, synchronous active-high reset
//            load_i            - latch x/y/w/h and point at the top-left pixel
//            advance_i         - step to the next pixel
//            x_i,y_i,w_i,h_i   - rectangle corner and extent
//            paddr_o           - byte address of the current pixel
//            last_o            - current pixel is the final one
//            empty_o           - rectangle on x/y/w/h inputs clips to nothing
// Revision : 1.0 - initial release
// ============================================================================
module vga_fill_addr_gen
    import vga_fb_pkg::*;
#(
    parameter logic [31:0] FB_BASE = FB_BASE_DEF,
    parameter int          FB_W    = FB_W_DEF,
    parameter int          FB_H    = FB_H_DEF
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        load_i,
    input  wire logic        advance_i,
    input  wire logic [9:0]  x_i,
    input  wire logic [9:0]  y_i,
    input  wire logic [9:0]  w_i,
    input  wire logic [9:0]  h_i,
    output logic      [31:0] paddr_o,
    output logic             last_o,
    output logic             empty_o
);

    localparam logic [PIX_CNT_W-1:0] FB_W_C = PIX_CNT_W'(FB_W);
    localparam logic [PIX_CNT_W-1:0] FB_H_C = PIX_CNT_W'(FB_H);

    logic [PIX_CNT_W-1:0] x_room, y_room;
    logic [PIX_CNT_W-1:0] eff_w_d, eff_h_d;
    logic [PIX_CNT_W-1:0] eff_w_q, eff_h_q;
    logic [PIX_CNT_W-1:0] col_q, row_q;
    logic [31:0]          start_addr;
    logic [31:0]          row_step;
    logic [31:0]          paddr_q;

    always_comb begin
        // Room left to the right/bottom edge; zero when the corner is off-screen.
        x_room     = ({1'b0, x_i} < FB_W_C) ? (FB_W_C - {1'b0, x_i}) : '0;
        y_room     = ({1'b0, y_i} < FB_H_C) ? (FB_H_C - {1'b0, y_i}) : '0;
        eff_w_d    = ({1'b0, w_i} < x_room) ? {1'b0, w_i} : x_room;
        eff_h_d    = ({1'b0, h_i} < y_room) ? {1'b0, h_i} : y_room;
        start_addr = FB_BASE + ((32'(y_i) * 32'(FB_W) + 32'(x_i)) << 2);
        // From the last pixel of a row to the first pixel of the next row.
        row_step   = 32'(FB_W_C - eff_w_q + 11'd1) << 2;
    end

    assign empty_o = (eff_w_d == '0) || (eff_h_d == '0);
    assign last_o  = (col_q == eff_w_q - 11'd1) && (row_q == eff_h_q - 11'd1);
    assign paddr_o = paddr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            eff_w_q <= '0;
            eff_h_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            paddr_q <= '0;
        end else if (load_i) begin
            eff_w_q <= eff_w_d;
            eff_h_q <= eff_h_d;
            col_q   <= '0;
            row_q   <= '0;
            paddr_q <= start_addr;
        end else if (advance_i) begin
            if (col_q == eff_w_q - 11'd1) begin
                col_q   <= '0;
                row_q   <= row_q + 11'd1;
                paddr_q <= paddr_q + row_step;
            end else begin
                col_q   <= col_q + 11'd1;
                paddr_q <= paddr_q + 32'd4;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_fill_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_fill_apb_master
// Purpose  : APB requester that fills a clipped rectangle of the VGA
//            framebuffer with one 24-bit colour, one write per pixel.
//            Define VGA_FILL_SYNC_EN to follow the last pixel with a write of
//            1 to the framebuffer sync register.
// Ports    : clock, reset           - clock, synchronous active-high reset
//            cmd_valid/cmd_ready    - command handshake
//            cmd_x/y/w/h, cmd_color - rectangle and {R,G,B} colour
//            busy, done, err        - status: in progress, 1-cycle completion
//                                     pulse, sticky slave error
//            m_apb                  - APB master modport
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_fill_apb_master
    import vga_fb_pkg::*;
#(
    parameter logic [31:0] FB_BASE      = FB_BASE_DEF,
    parameter logic [31:0] FB_SYNC_ADDR = FB_SYNC_ADDR_DEF,
    parameter int          FB_W         = FB_W_DEF,
    parameter int          FB_H         = FB_H_DEF
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        cmd_valid,
    output logic             cmd_ready,
    input  wire logic [9:0]  cmd_x,
    input  wire logic [9:0]  cmd_y,
    input  wire logic [9:0]  cmd_w,
    input  wire logic [9:0]  cmd_h,
    input  wire logic [23:0] cmd_color,
    output logic             busy,
    output logic             done,
    output logic             err,
    vga_fb_fill_apb_master_if.master m_apb
);

    fill_state_t state_q;
    logic        cmd_ready_q, busy_q, done_q, err_q;
    logic        psel_q, penable_q, pwrite_q, sync_phase_q;
    logic [31:0] pwdata_q;

    logic        gen_load, gen_advance, gen_last, gen_empty;
    logic [31:0] gen_paddr;
    logic        prdata_unused;

    assign gen_load    = (state_q == ST_IDLE) && cmd_valid;
    assign gen_advance = (state_q == ST_ACCESS) && m_apb.m_pready
                         && !m_apb.m_pslverr && !gen_last;

    vga_fill_addr_gen #(
        .FB_BASE (FB_BASE),
        .FB_W    (FB_W),
        .FB_H    (FB_H)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .load_i    (gen_load),
        .advance_i (gen_advance),
        .x_i       (cmd_x),
        .y_i       (cmd_y),
        .w_i       (cmd_w),
        .h_i       (cmd_h),
        .paddr_o   (gen_paddr),
        .last_o    (gen_last),
        .empty_o   (gen_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            sync_phase_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        err_q       <= 1'b0;
                        pwdata_q    <= {8'h00, cmd_color};
                        if (gen_empty) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_SETUP;
                            psel_q   <= 1'b1;
                            pwrite_q <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (m_apb.m_pready) begin
                        penable_q <= 1'b0;
                        if (m_apb.m_pslverr || gen_last) begin
`ifdef VGA_FILL_SYNC_EN
                            if (!m_apb.m_pslverr) begin
                                state_q      <= ST_SYNC_SETUP;
                                sync_phase_q <= 1'b1;
                                pwdata_q     <= 32'h1;
                            end else begin
                                state_q  <= ST_FINISH;
                                done_q   <= 1'b1;
                                err_q    <= 1'b1;
                                psel_q   <= 1'b0;
                                pwrite_q <= 1'b0;
                            end
`else
                            state_q  <= ST_FINISH;
                            done_q   <= 1'b1;
                            err_q    <= err_q | m_apb.m_pslverr;
                            psel_q   <= 1'b0;
                            pwrite_q <= 1'b0;
`endif
                        end else begin
                            state_q <= ST_SETUP;
                        end
                    end
                end
`ifdef VGA_FILL_SYNC_EN
                ST_SYNC_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_SYNC_ACCESS;
                end
                ST_SYNC_ACCESS: begin
                    if (m_apb.m_pready) begin
                        state_q   <= ST_FINISH;
                        done_q    <= 1'b1;
                        err_q     <= err_q | m_apb.m_pslverr;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                    end
                end
`endif
                ST_FINISH: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    cmd_ready_q  <= 1'b1;
                    sync_phase_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    pwrite_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;

    // Both mux inputs are registers, so the address is glitch-free.
    assign m_apb.m_paddr   = sync_phase_q ? FB_SYNC_ADDR : gen_paddr;
    assign m_apb.m_psel    = psel_q;
    assign m_apb.m_penable = penable_q;
    assign m_apb.m_pwrite  = pwrite_q;
    assign m_apb.m_pprot   = 3'b000;
    assign m_apb.m_pwdata  = pwdata_q;
    assign m_apb.m_pstrb   = 4'hF;

    // Write-only master: read data is never consumed.
    assign prdata_unused   = ^m_apb.m_prdata;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_fill_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_fill_apb_master
// Purpose  : Self-checking bench for vga_fb_fill_apb_master. An APB completer
//            model with programmable wait states and error injection pops
//            expected writes from a scoreboard queue on every completed
//            transfer. Follows VGA_FILL_SYNC_EN in the same way as the RTL.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_fill_apb_master;

`ifdef VGA_FILL_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [23:0] cmd_color;
    wire         cmd_ready, busy, done, err;

    always #5 clock = ~clock;

    vga_fb_fill_apb_master_if bus ();

    vga_fb_fill_apb_master dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .m_apb     (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t sb[$];

    int xfer_idx   = 0;
    int err_idx    = -1;
    int wait_idx   = -1;
    int wait_n     = 0;
    int waits_left = 0;
    bit psel_seen  = 1'b0;

    // APB completer model: decides pready/pslverr for the coming edge.
    always @(negedge clock) begin
        xfer_t e;
        if (bus.m_psel) psel_seen = 1'b1;
        if (bus.m_psel && !bus.m_penable) begin
            waits_left    = (xfer_idx == wait_idx) ? wait_n : 0;
            bus.m_pready  = 1'b0;
            bus.m_pslverr = 1'b0;
        end else if (bus.m_psel && bus.m_penable) begin
            if (waits_left > 0) begin
                waits_left--;
                bus.m_pready  = 1'b0;
                bus.m_pslverr = 1'b0;
                if (sb.size() != 0) begin
                    check_eq("wait_addr", bus.m_paddr, sb[0].addr);
                    check_eq("wait_data", bus.m_pwdata, sb[0].data);
                end
            end else begin
                bus.m_pready  = 1'b1;
                bus.m_pslverr = (xfer_idx == err_idx);
                check_eq("write_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("paddr", bus.m_paddr, e.addr);
                    check_eq("pwdata", bus.m_pwdata, e.data);
                    check_eq("pwrite_pstrb_pprot",
                             {25'd0, bus.m_pwrite, bus.m_pstrb, bus.m_pprot},
                             {25'd0, 1'b1, 4'hF, 3'b000});
                end
                xfer_idx++;
            end
        end else begin
            bus.m_pready  = 1'b0;
            bus.m_pslverr = 1'b0;
        end
    end

    // Expected writes of a fill, optionally truncated after max_xfers pixels.
    task automatic push_fill(input int x, input int y, input int w, input int h,
                             input logic [23:0] color, input int max_xfers,
                             input bit with_sync);
        int ew, eh, n;
        xfer_t e;
        ew = (x >= 640) ? 0 : ((w < 640 - x) ? w : 640 - x);
        eh = (y >= 480) ? 0 : ((h < 480 - y) ? h : 480 - y);
        n  = 0;
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                if (n < max_xfers) begin
                    e.addr = 32'h2100_0000 + 32'(((y + r) * 640 + x + c) * 4);
                    e.data = {8'h00, color};
                    sb.push_back(e);
                end
                n++;
            end
        end
        if (with_sync && ew > 0 && eh > 0) begin
            e.addr = 32'h211F_FFFC;
            e.data = 32'h1;
            sb.push_back(e);
        end
    endtask

    task automatic accept_cmd(input int x, input int y, input int w, input int h,
                              input logic [23:0] color);
        @(negedge clock);
        check_eq("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        xfer_idx  = 0;
        psel_seen = 1'b0;
        cmd_valid = 1'b1;
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = color;
        @(negedge clock);
        cmd_valid = 1'b0;
        check_eq("busy_after_accept", {30'd0, busy, cmd_ready}, 32'b10);
        check_eq("err_cleared_on_accept", {31'd0, err}, 32'd0);
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [23:0] color, input int exp_lat,
                           input logic exp_err);
        int lat;
        accept_cmd(x, y, w, h, color);
        lat = 1;
        while (!done && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        check_eq("done_latency", 32'(lat), 32'(exp_lat));
        check_eq("err_at_done", {31'd0, err}, {31'd0, exp_err});
        @(negedge clock);
        check_eq("idle_after_done", {29'd0, done, busy, cmd_ready}, 32'b001);
        check_eq("err_sticky", {31'd0, err}, {31'd0, exp_err});
        check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int  cyc;
        bit  done_seen;
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_x         = '0;
        cmd_y         = '0;
        cmd_w         = '0;
        cmd_h         = '0;
        cmd_color     = '0;
        bus.m_pready  = 1'b0;
        bus.m_pslverr = 1'b0;
        bus.m_prdata  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clock);
        check_eq("reset_status", {28'd0, cmd_ready, busy, done, err}, 32'b1000);
        check_eq("reset_apb_ctrl", {29'd0, bus.m_psel, bus.m_penable, bus.m_pwrite}, 32'd0);
        check_eq("reset_paddr", bus.m_paddr, 32'd0);
        check_eq("reset_pwdata", bus.m_pwdata, 32'd0);
        reset = 1'b0;

        // 2x2 red at origin, no waits.
        push_fill(0, 0, 2, 2, 24'hFF0000, 99, SYNC);
        run_cmd(0, 0, 2, 2, 24'hFF0000, 9 + (SYNC ? 2 : 0), 1'b0);

        // Same with 3 wait states on the 2nd pixel.
        wait_idx = 1;
        wait_n   = 3;
        push_fill(0, 0, 2, 2, 24'hFF0000, 99, SYNC);
        run_cmd(0, 0, 2, 2, 24'hFF0000, 12 + (SYNC ? 2 : 0), 1'b0);
        wait_idx = -1;
        wait_n   = 0;

        // Bottom-right corner clipped to 2x1.
        push_fill(638, 479, 5, 4, 24'h12AB34, 99, SYNC);
        run_cmd(638, 479, 5, 4, 24'h12AB34, 5 + (SYNC ? 2 : 0), 1'b0);

        // Off-centre 3x2 fill exercising the row step.
        push_fill(100, 50, 3, 2, 24'h00FF00, 99, SYNC);
        run_cmd(100, 50, 3, 2, 24'h00FF00, 13 + (SYNC ? 2 : 0), 1'b0);

        // Empty commands: zero width, and corner fully off-screen.
        run_cmd(5, 5, 0, 4, 24'h0000FF, 1, 1'b0);
        check_eq("empty_no_psel", {31'd0, psel_seen}, 32'd0);
        run_cmd(700, 10, 4, 4, 24'h0000FF, 1, 1'b0);
        check_eq("offscreen_no_psel", {31'd0, psel_seen}, 32'd0);

        // Slave error on the 3rd pixel: no 4th write, no sync write.
        err_idx = 2;
        push_fill(0, 0, 2, 2, 24'hFF0000, 3, 1'b0);
        run_cmd(0, 0, 2, 2, 24'hFF0000, 7, 1'b1);
        err_idx = -1;

        // Next command clears err on accept (checked inside accept_cmd).
        push_fill(1, 1, 1, 1, 24'hABCDEF, 99, SYNC);
        run_cmd(1, 1, 1, 1, 24'hABCDEF, 3 + (SYNC ? 2 : 0), 1'b0);

        // Reset during an ACCESS phase.
        push_fill(0, 0, 2, 2, 24'hFF0000, 99, SYNC);
        accept_cmd(0, 0, 2, 2, 24'hFF0000);
        cyc = 0;
        while (!(bus.m_psel && bus.m_penable) && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("reached_access", {30'd0, bus.m_psel, bus.m_penable}, 32'b11);
        reset = 1'b1;
        @(negedge clock);
        check_eq("reset_mid_apb", {29'd0, bus.m_psel, bus.m_penable, cmd_ready}, 32'b001);
        check_eq("reset_mid_busy_done", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;
        sb.delete();
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done || bus.m_psel) done_seen = 1'b1;
        end
        check_eq("no_done_after_reset", {31'd0, done_seen}, 32'd0);
        check_eq("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
